// File: rtl/link_table_pkg.sv
// Shared types and helpers for the link-table init engine and its
// link-table update path: pointer geometry, FSM states and word slicing.
package link_table_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } lt_state_e;

    // Pointer width: page index plus one NULL flag bit on top.
    function automatic int unsigned calc_ptr_width(input int unsigned page_num_log);
        return page_num_log + 32'd1;
    endfunction

    // Memory words needed to hold one pointer (ceiling division).
    function automatic int unsigned calc_wpp(input int unsigned ptr_width,
                                             input int unsigned data_width);
        return (ptr_width + data_width - 32'd1) / data_width;
    endfunction

    // Width of an index counting 0..n-1, never narrower than one bit.
    function automatic int unsigned calc_idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

    // NULL marker: only the flag bit (the MSB) set.
    function automatic logic [63:0] calc_null_ptr(input int unsigned ptr_width);
        return 64'd1 << (ptr_width - 32'd1);
    endfunction

    // Word w of a pointer, least-significant word first; bits above the
    // pointer read as zero, which pads the top word.
    function automatic logic [63:0] ptr_slice(input logic [63:0]   ptr,
                                              input int unsigned   w,
                                              input int unsigned   data_width);
        logic [63:0] shifted;
        logic [63:0] mask;
        shifted = ptr >> (w * data_width);
        mask    = (data_width >= 32'd64) ? {64{1'b1}}
                                         : ((64'd1 << data_width) - 64'd1);
        return shifted & mask;
    endfunction

endpackage

// File: rtl/link_ptr_splitter.sv
// Combinational pointer-to-word mux: selects word w_i of a pointer for a
// link-memory write. Shared by the init engine and the link-table update path.
module link_ptr_splitter
    import link_table_pkg::*;
#(
    parameter int unsigned PTR_WIDTH  = 13,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned W_WIDTH    = 1
) (
    input  logic [PTR_WIDTH-1:0]  ptr_i,
    input  logic [W_WIDTH-1:0]    w_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    // Select the requested word of the zero-padded pointer.
    always_comb begin
        data_o = DATA_WIDTH'(ptr_slice(64'(ptr_i), 32'(w_i), DATA_WIDTH));
    end

endmodule

// File: rtl/link_table_init_engine.sv
// Linked-list page table initialiser. Walks N pages, writing each page's
// next pointer (p+1, or NULL for the last page) into link memory through a
// valid/ready port, then publishes free-list head/tail/count.
module link_table_init_engine
    import link_table_pkg::*;
#(
    parameter int unsigned PAGE_NUM_LOG = 12,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned BASE_ADDR    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [PAGE_NUM_LOG:0]   cfg_page_num,
    input  logic                    abort,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    aborted,
    output logic                    free_list_valid,
    output logic [PAGE_NUM_LOG:0]   free_head,
    output logic [PAGE_NUM_LOG:0]   free_tail,
    output logic [PAGE_NUM_LOG:0]   free_count
);

    localparam int unsigned PTR_WIDTH = calc_ptr_width(PAGE_NUM_LOG);
    localparam int unsigned CNT_WIDTH = PAGE_NUM_LOG + 1;
    localparam int unsigned WPP       = calc_wpp(PTR_WIDTH, DATA_WIDTH);
    localparam int unsigned W_WIDTH   = calc_idx_width(WPP);

    localparam logic [PTR_WIDTH-1:0] NULL_PTR  = PTR_WIDTH'(calc_null_ptr(PTR_WIDTH));
    localparam logic [CNT_WIDTH-1:0] MAX_PAGES = {1'b1, {PAGE_NUM_LOG{1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [W_WIDTH-1:0]   W_LAST    = W_WIDTH'(WPP - 1);
    localparam logic [W_WIDTH-1:0]   W_ONE     = W_WIDTH'(1);

    lt_state_e              state_q, state_d;
    logic [CNT_WIDTH-1:0]   n_q, n_d;
    logic [CNT_WIDTH-1:0]   p_q, p_d;
    logic [W_WIDTH-1:0]     w_q, w_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   aborted_q, aborted_d;
    logic                   flv_q, flv_d;
    logic [PTR_WIDTH-1:0]   head_q, head_d;
    logic [PTR_WIDTH-1:0]   tail_q, tail_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    logic                   in_write_s;
    logic                   last_page_s;
    logic                   start_legal_s;
    logic [PTR_WIDTH-1:0]   ptr_s;
    logic [ADDR_WIDTH-1:0]  addr_s;

    // Decode datapath controls from the current state and page/word counters.
    always_comb begin
        in_write_s    = (state_q == WRITE);
        last_page_s   = (p_q == (n_q - CNT_ONE));
        start_legal_s = (cfg_page_num != {CNT_WIDTH{1'b0}}) && (cfg_page_num <= MAX_PAGES);
        addr_s        = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(32'(p_q) * WPP) + ADDR_WIDTH'(w_q);
        if (!in_write_s) begin
            ptr_s = {PTR_WIDTH{1'b0}};
        end else if (last_page_s) begin
            ptr_s = NULL_PTR;
        end else begin
            ptr_s = PTR_WIDTH'(p_q + CNT_ONE);
        end
    end

    // Gated ptr keeps wr_data at zero outside WRITE.
    link_ptr_splitter #(
        .PTR_WIDTH  (PTR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .W_WIDTH    (W_WIDTH)
    ) u_splitter (
        .ptr_i  (ptr_s),
        .w_i    (w_q),
        .data_o (wr_data)
    );

    // Next-state and pulse logic; abort outranks a same-cycle accept.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        p_d       = p_q;
        w_d       = w_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        aborted_d = 1'b0;
        flv_d     = flv_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (start && start_legal_s) begin
                    state_d = WRITE;
                    n_d     = cfg_page_num;
                    p_d     = {CNT_WIDTH{1'b0}};
                    w_d     = {W_WIDTH{1'b0}};
                    flv_d   = 1'b0;
                end else if (start) begin
                    err_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                    p_d       = {CNT_WIDTH{1'b0}};
                    w_d       = {W_WIDTH{1'b0}};
                end else if (wr_ready) begin
                    if (w_q == W_LAST) begin
                        w_d = {W_WIDTH{1'b0}};
                        if (last_page_s) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            flv_d   = 1'b1;
                            head_d  = {PTR_WIDTH{1'b0}};
                            tail_d  = PTR_WIDTH'(n_q - CNT_ONE);
                            count_d = n_q;
                        end else begin
                            p_d = p_q + CNT_ONE;
                        end
                    end else begin
                        w_d = w_q + W_ONE;
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= {CNT_WIDTH{1'b0}};
            p_q       <= {CNT_WIDTH{1'b0}};
            w_q       <= {W_WIDTH{1'b0}};
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            flv_q     <= 1'b0;
            head_q    <= {PTR_WIDTH{1'b0}};
            tail_q    <= {PTR_WIDTH{1'b0}};
            count_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            p_q       <= p_d;
            w_q       <= w_d;
            done_q    <= done_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
            flv_q     <= flv_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    assign wr_valid        = in_write_s;
    assign busy            = in_write_s;
    assign wr_addr         = in_write_s ? addr_s : {ADDR_WIDTH{1'b0}};
    assign done            = done_q;
    assign err             = err_q;
    assign aborted         = aborted_q;
    assign free_list_valid = flv_q;
    assign free_head       = head_q;
    assign free_tail       = tail_q;
    assign free_count      = count_q;

endmodule

// File: tb/tb_link_table_init_engine.sv
// Self-checking bench for link_table_init_engine with PAGE_NUM_LOG=4,
// DATA_WIDTH=4 (PTR_WIDTH=5, WPP=2, NULL=0x10). Expected writes are pushed
// to a scoreboard queue at start and popped on each accepted write.
module tb_link_table_init_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  cfg_page_num;
    logic        abort;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [3:0]  wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        aborted;
    logic        free_list_valid;
    logic [4:0]  free_head;
    logic [4:0]  free_tail;
    logic [4:0]  free_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  data;
    } wr_t;

    wr_t exp_q[$];

    link_table_init_engine #(
        .PAGE_NUM_LOG (4),
        .DATA_WIDTH   (4),
        .ADDR_WIDTH   (16),
        .BASE_ADDR    (0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfg_page_num    (cfg_page_num),
        .abort           (abort),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .aborted         (aborted),
        .free_list_valid (free_list_valid),
        .free_head       (free_head),
        .free_tail       (free_tail),
        .free_count      (free_count)
    );

    always #5 clk = ~clk;

    task automatic push_expected(input int n);
        int ptr;
        wr_t e;
        for (int p = 0; p < n; p++) begin
            ptr = (p == n - 1) ? 16 : p + 1;
            for (int w = 0; w < 2; w++) begin
                e.addr = 16'(2 * p + w);
                e.data = 4'((ptr >> (4 * w)) & 15);
                exp_q.push_back(e);
            end
        end
    endtask

    // Run one init of n pages. stall: ready 1,0,1,0...; abort_at: abort on
    // that accept number (0 = never); restart_at: pulse an ignored start.
    task automatic do_init(input int n, input int stall, input int abort_at,
                           input int restart_at, input int exp_done);
        wr_t got;
        wr_t prev;
        wr_t e;
        bit  stalled = 1'b0;
        bit  fin = 1'b0;
        int  cyc;
        int  accepts = 0;
        @(negedge clk);
        start = 1'b1;
        cfg_page_num = 5'(n);
        push_expected(n);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!fin && cyc < 300) begin
            wr_ready = (stall != 0) ? ((cyc % 2) == 1) : 1'b1;
            abort = (abort_at > 0) && (accepts == abort_at - 1) && wr_ready;
            start = (restart_at == cyc);
            cfg_page_num = (restart_at == cyc) ? 5'd1 : 5'(n);
            got.addr = wr_addr;
            got.data = wr_data;
            if (done) begin
                fin = 1'b1;
                n_cmp++;
                if (cyc !== exp_done) begin
                    n_err++; $display("FAIL done_latency n=%0d: got cycle %0d, want %0d", n, cyc, exp_done);
                end
                n_cmp++;
                if ({free_list_valid, free_head, free_tail, free_count} !== {1'b1, 5'd0, 5'(n - 1), 5'(n)}) begin
                    n_err++;
                    $display("FAIL free_list n=%0d: got v=%0b h=%0d t=%0d c=%0d, want v=1 h=0 t=%0d c=%0d",
                             n, free_list_valid, free_head, free_tail, free_count, n - 1, n);
                end
                n_cmp++;
                if (exp_q.size() !== 0) begin
                    n_err++; $display("FAIL missing_writes n=%0d: got %0d left, want 0", n, exp_q.size());
                end
            end else begin
                n_cmp++;
                if ({busy, wr_valid, free_list_valid} !== 3'b110) begin
                    n_err++;
                    $display("FAIL write_flags cyc=%0d: got busy=%0b valid=%0b flv=%0b, want 1 1 0",
                             cyc, busy, wr_valid, free_list_valid);
                end
                if (stalled) begin
                    n_cmp++;
                    if (got !== prev) begin
                        n_err++;
                        $display("FAIL stall_stable cyc=%0d: got (%0d,%0d), want (%0d,%0d)",
                                 cyc, got.addr, got.data, prev.addr, prev.data);
                    end
                end
                if (wr_ready) begin
                    stalled = 1'b0;
                    accepts++;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++; $display("FAIL extra_write: got (%0d,%0d), want none", got.addr, got.data);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            n_err++;
                            $display("FAIL write_%0d: got (%0d,%0d), want (%0d,%0d)",
                                     accepts, got.addr, got.data, e.addr, e.data);
                        end
                    end
                end else begin
                    stalled = 1'b1;
                    prev = got;
                end
                if (abort) begin
                    @(negedge clk);
                    abort = 1'b0;
                    start = 1'b0;
                    wr_ready = 1'b1;
                    n_cmp++;
                    if ({aborted, wr_valid, busy, free_list_valid} !== 4'b1000) begin
                        n_err++;
                        $display("FAIL abort_taken: got aborted=%0b valid=%0b busy=%0b flv=%0b, want 1 0 0 0",
                                 aborted, wr_valid, busy, free_list_valid);
                    end
                    exp_q.delete();
                    @(negedge clk);
                    n_cmp++;
                    if ({aborted, wr_valid} !== 2'b00) begin
                        n_err++; $display("FAIL abort_pulse_end: got aborted=%0b valid=%0b, want 0 0", aborted, wr_valid);
                    end
                    return;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        abort = 1'b0;
        wr_ready = 1'b1;
        if (!fin) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout n=%0d: got no done, want done at cycle %0d", n, exp_done);
            exp_q.delete();
        end else begin
            n_cmp++;
            if ({done, busy, free_list_valid} !== 3'b001) begin
                n_err++;
                $display("FAIL after_done: got done=%0b busy=%0b flv=%0b, want 0 0 1", done, busy, free_list_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        wr_ready = 1'b1;
        cfg_page_num = 5'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({wr_valid, wr_addr, wr_data, busy, done, err, aborted, free_list_valid,
             free_head, free_tail, free_count} !== 44'd0) begin
            n_err++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_init(4, 0, 0, 0, 9);
    endtask

    task automatic test_stall();
        do_init(4, 1, 0, 0, 16);
    endtask

    task automatic test_boundaries();
        do_init(1, 0, 0, 0, 3);
        do_init(16, 0, 0, 0, 33);
    endtask

    task automatic test_err();
        int bad[2] = '{0, 17};
        logic [4:0] count_before;
        logic flv_before;
        foreach (bad[i]) begin
            count_before = free_count;
            flv_before = free_list_valid;
            @(negedge clk);
            start = 1'b1;
            cfg_page_num = 5'(bad[i]);
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if ({err, busy, wr_valid} !== 3'b100) begin
                n_err++;
                $display("FAIL err_pulse cfg=%0d: got err=%0b busy=%0b valid=%0b, want 1 0 0",
                         bad[i], err, busy, wr_valid);
            end
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                n_cmp++;
                if ({err, busy, wr_valid} !== 3'b000) begin
                    n_err++;
                    $display("FAIL err_idle cfg=%0d: got err=%0b busy=%0b valid=%0b, want 0 0 0",
                             bad[i], err, busy, wr_valid);
                end
            end
            n_cmp++;
            if ({free_list_valid, free_count} !== {flv_before, count_before}) begin
                n_err++;
                $display("FAIL err_keeps_free cfg=%0d: got v=%0b c=%0d, want v=%0b c=%0d",
                         bad[i], free_list_valid, free_count, flv_before, count_before);
            end
        end
    endtask

    task automatic test_abort();
        do_init(4, 0, 3, 0, 0);
        do_init(2, 0, 0, 0, 5);
    endtask

    task automatic test_back_to_back();
        do_init(3, 0, 0, 2, 7);
        do_init(5, 0, 0, 0, 11);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        cfg_page_num = 5'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL mid_busy: got %0b, want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({wr_valid, wr_addr, wr_data, busy, done, err, aborted, free_list_valid,
             free_head, free_tail, free_count} !== 44'd0) begin
            n_err++; $display("FAIL mid_reset_outputs: got nonzero outputs, want all 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_init(3, 0, 0, 0, 7);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_boundaries();
        test_err();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/link_table_init_engine.md
Name: link_table_init_engine

Overview:
Programmable initialiser for a linked-list page table. On a start request it walks a run-time number of pages and writes each page's next-pointer into link memory, chaining page p to p+1 and terminating the last page with a NULL marker. Pointers wider than the memory word are split across several consecutive words. Writes go out through a valid/ready port. On completion the block publishes the free-list head, tail and count to the link-table manager.

Parameters:
PAGE_NUM_LOG, 12, log2 of the maximum page count; the maximum is MAX_PAGES = 2^PAGE_NUM_LOG.
DATA_WIDTH, 8, link-memory word width.
ADDR_WIDTH, 16, link-memory address width.
BASE_ADDR, 0, link-memory address of word 0 of page 0.
PTR_WIDTH (localparam), PAGE_NUM_LOG+1; the MSB is the NULL flag.
WPP (localparam), ceil(PTR_WIDTH/DATA_WIDTH), words per page entry.
NULL_PTR (localparam), {1'b1, PAGE_NUM_LOG'b0}.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
start  in  1  single-cycle init request
cfg_page_num  in  PAGE_NUM_LOG+1  pages to initialise; legal range 1..MAX_PAGES
abort  in  1  cancel an init in progress
wr_valid  out  1  link-memory write request
wr_ready  in  1  link memory accepts the write
wr_addr  out  ADDR_WIDTH  write address
wr_data  out  DATA_WIDTH  write data
busy  out  1  high in WRITE
done  out  1  single-cycle pulse on successful completion
err  out  1  single-cycle pulse when start is rejected
aborted  out  1  single-cycle pulse when an abort is taken
free_list_valid  out  1  head/tail/count are valid
free_head  out  PTR_WIDTH  first free page
free_tail  out  PTR_WIDTH  last free page
free_count  out  PAGE_NUM_LOG+1  number of free pages

Behaviour:
- Reset is rst_n, asynchronous, active-low, on clock clk. During reset the FSM is in IDLE and every output is 0.
- FSM states are IDLE, WRITE and DONE.
- IDLE, start=1, cfg_page_num in 1..MAX_PAGES:
  - latch N = cfg_page_num; page index p = 0, word index w = 0.
  - clear free_list_valid; go to WRITE.
  - wr_valid is asserted in the next cycle.
- IDLE, start=1, cfg_page_num = 0 or > MAX_PAGES: err pulses for 1 cycle, the FSM stays in IDLE, free_list_* is unchanged.
- start is ignored in WRITE and DONE.
- WRITE:
  - wr_valid = 1.
  - wr_addr = BASE_ADDR + p*WPP + w, computed modulo 2^ADDR_WIDTH.
  - wr_data = slice w of ptr; word 0 holds ptr[DATA_WIDTH-1:0], and the top word is zero-padded.
  - ptr = p+1 when p < N-1; ptr = NULL_PTR when p = N-1.
  - wr_addr and wr_data stay stable while wr_valid && !wr_ready. wr_valid is never withdrawn without an accept, except on abort.
  - On accept (wr_valid && wr_ready): w increments. When w = WPP-1, w returns to 0 and p increments.
  - Accept of the last word (p = N-1, w = WPP-1) moves the FSM to DONE.
- Throughput is 1 word/cycle with wr_ready held high. With start at cycle t, write k is accepted at t+1+k and done pulses at t+1+N*WPP.
- DONE lasts 1 cycle:
  - done = 1, free_list_valid = 1.
  - free_head = 0, free_tail = N-1, free_count = N.
  - Return to IDLE. free_* holds until the next accepted start or reset.
- abort in WRITE:
  - Next cycle: wr_valid = 0, busy = 0, aborted pulses, state = IDLE, free_list_valid stays 0.
  - Abort has priority over an accept in the same cycle; that write may already have landed in memory.
- abort in IDLE or DONE is ignored.
- The N = 1 boundary issues a single page entry, NULL_PTR, then head = tail = 0 and count = 1.
- N = MAX_PAGES needs p to count to MAX_PAGES-1 without overflow. Size the counter at PAGE_NUM_LOG+1 bits.
- Reset mid-operation returns to IDLE with all outputs 0. No partial-state recovery.

Decomposition:
- Shared package link_table_pkg holds:
  - PTR_WIDTH, NULL_PTR and WPP computations;
  - the FSM state enum {IDLE, WRITE, DONE};
  - the function ptr_slice(ptr, w) that returns a DATA_WIDTH word.
- One natural sub-module: link_ptr_splitter, a combinational ptr/w to wr_data mux, reused by the link-table update path.

Test Plan:
Use PAGE_NUM_LOG=4, DATA_WIDTH=4, BASE_ADDR=0, so PTR_WIDTH=5, WPP=2, NULL=0x10.
1. start with cfg_page_num=4, wr_ready=1 -> (addr,data) sequence (0,1)(1,0)(2,2)(3,0)(4,3)(5,0)(6,0)(7,1); done at t+9; head=0, tail=3, count=4, free_list_valid=1.
2. Same as 1 with wr_ready toggling 1,0,1,0 -> addr/data stable during each stall, same 8 writes, done at t+1+15.
3. cfg_page_num=1 -> writes (0,0)(1,1); head=tail=0, count=1. cfg_page_num=16 -> last writes (30,0)(31,1), count=16.
4. start with cfg_page_num=0, then again with 17 -> err pulses each time, wr_valid never rises, busy=0.
5. abort asserted at the 3rd accept -> aborted pulses next cycle, wr_valid=0, free_list_valid=0. A following start with cfg_page_num=2 completes normally with count=2.
6. start while busy is ignored. rst_n asserted mid-WRITE -> all outputs 0 immediately; after release, start with cfg_page_num=3 completes with tail=2.
